// File: rtl/wb_cmd_master.sv
//------------------------------------------------------------------------------
// Module   : wb_cmd_master
// Brief    : Wishbone classic initiator driven by a valid/ready command stream,
//            returning data and status on a valid/ready response stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_cmd_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int RETRY_LIMIT  = 3,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  // command stream
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic                    cmd_we,
  input  logic [SELECT_WIDTH-1:0] cmd_sel,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  // response stream
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]              rsp_status,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  // Wishbone initiator
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_we_o,
  output logic [SELECT_WIDTH-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  input  logic                    wb_rty_i,
  output logic                    wb_cyc_o
);

  localparam int c_tmo_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int c_rty_w = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam bit c_tmo_en = (TIMEOUT != 0);
  localparam logic [c_tmo_w-1:0] c_tmo_max  = c_tmo_w'(TIMEOUT);
  localparam logic [c_tmo_w-1:0] c_tmo_last = (TIMEOUT > 0) ? c_tmo_w'(TIMEOUT - 1) : '0;
  localparam logic [c_rty_w-1:0] c_rty_max  = c_rty_w'(RETRY_LIMIT);

  localparam logic [1:0] c_st_ok  = 2'd0;
  localparam logic [1:0] c_st_err = 2'd1;
  localparam logic [1:0] c_st_rty = 2'd2;
  localparam logic [1:0] c_st_tmo = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUS     = 2'd1,
    S_BACKOFF = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [c_tmo_w-1:0]    r_tmo_cnt;
  logic [c_rty_w-1:0]    r_rty_cnt;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_retry;
  logic [1:0]            w_status;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_accept = (r_state == S_IDLE) && cmd_valid && cmd_ready;

  // Termination priority is ack > err > rty > timeout; all decided while stb is high.
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    w_retry      = 1'b0;
    w_status     = c_st_ok;
    w_rdata      = '0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_BUS;
      end
      S_BUS: begin
        if (wb_stb_o) begin
          if (wb_ack_i) begin
            w_done  = 1'b1;
            w_rdata = wb_we_o ? '0 : wb_dat_i;
          end else if (wb_err_i) begin
            w_done   = 1'b1;
            w_status = c_st_err;
          end else if (wb_rty_i) begin
            if (r_rty_cnt < c_rty_max) begin
              w_retry = 1'b1;
            end else begin
              w_done   = 1'b1;
              w_status = c_st_rty;
            end
          end else if (c_tmo_en && (r_tmo_cnt == c_tmo_last)) begin
            w_done   = 1'b1;
            w_status = c_st_tmo;
          end
        end
        if (w_done) begin
          w_state_next = S_RESP;
        end else if (w_retry) begin
          w_state_next = S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        w_state_next = S_BUS;
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outputs are registered from the next state so cyc/stb/ready change on the edge
  // that enters the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready  <= 1'b0;
      rsp_data   <= '0;
      rsp_status <= c_st_ok;
      rsp_valid  <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
      r_tmo_cnt  <= '0;
      r_rty_cnt  <= '0;
    end else begin
      cmd_ready <= (w_state_next == S_IDLE);
      wb_cyc_o  <= (w_state_next == S_BUS);
      wb_stb_o  <= (w_state_next == S_BUS);

      if (w_accept) begin
        wb_adr_o  <= cmd_addr;
        wb_dat_o  <= cmd_data;
        wb_we_o   <= cmd_we;
        wb_sel_o  <= cmd_sel;
        r_rty_cnt <= '0;
      end else if (w_retry) begin
        r_rty_cnt <= r_rty_cnt + 1'b1;
      end

      // Timer restarts on every entry to BUS, including re-issues after backoff.
      if (r_state == S_BUS) begin
        if (r_tmo_cnt != c_tmo_max) r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end

      if (w_done) begin
        rsp_valid  <= 1'b1;
        rsp_status <= w_status;
        rsp_data   <= w_rdata;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid  <= 1'b0;
        rsp_status <= c_st_ok;
        rsp_data   <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
//------------------------------------------------------------------------------
// Module   : tb_wb_cmd_master
// Brief    : Randomised self-checking bench for wb_cmd_master with a scripted slave.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_cmd_master;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int SELECT_WIDTH = 4;
  localparam int RETRY_LIMIT  = 3;
  localparam int TIMEOUT      = 16;

  localparam logic [2:0] c_k_ack = 3'b001;
  localparam logic [2:0] c_k_err = 3'b010;
  localparam logic [2:0] c_k_rty = 3'b100;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [ADDR_WIDTH-1:0]   cmd_addr = '0;
  logic [DATA_WIDTH-1:0]   cmd_data = '0;
  logic                    cmd_we = 1'b0;
  logic [SELECT_WIDTH-1:0] cmd_sel = '0;
  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic [DATA_WIDTH-1:0]   rsp_data;
  logic [1:0]              rsp_status;
  logic                    rsp_valid;
  logic                    rsp_ready = 1'b0;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i = '0;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic                    wb_we_o;
  logic [SELECT_WIDTH-1:0] wb_sel_o;
  logic                    wb_stb_o;
  logic                    wb_ack_i = 1'b0;
  logic                    wb_err_i = 1'b0;
  logic                    wb_rty_i = 1'b0;
  logic                    wb_cyc_o;

  wb_cmd_master #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .SELECT_WIDTH(SELECT_WIDTH),
    .RETRY_LIMIT (RETRY_LIMIT),
    .TIMEOUT     (TIMEOUT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_we    (cmd_we),
    .cmd_sel   (cmd_sel),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .rsp_data  (rsp_data),
    .rsp_status(rsp_status),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_i  (wb_dat_i),
    .wb_dat_o  (wb_dat_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_stb_o  (wb_stb_o),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .wb_rty_i  (wb_rty_i),
    .wb_cyc_o  (wb_cyc_o)
  );

  always #5 clk = ~clk;

  int cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_no);
    end
  endtask

  // Per-attempt slave script: wait states before terminating, and which of ack/err/rty.
  int         plan_wait [RETRY_LIMIT+1];
  logic [2:0] plan_kind [RETRY_LIMIT+1];
  logic [DATA_WIDTH-1:0]   slv_rdata = '0;
  logic                    spur_en = 1'b0;
  logic                    exp_we = 1'b0;
  logic [ADDR_WIDTH-1:0]   exp_adr = '0;
  logic [DATA_WIDTH-1:0]   exp_dat = '0;
  logic [SELECT_WIDTH-1:0] exp_sel = '0;

  int slv_b = 0, slv_c = 0, slv_stb_total = 0, slv_bursts = 0, slv_first = 0;

  // Scripted slave; outside stb it optionally throws spurious terminations.
  always @(negedge clk) begin
    logic [2:0] term;
    if (cmd_ready || rst) begin
      slv_b = 0; slv_c = 0; slv_stb_total = 0; slv_bursts = 0; slv_first = 0;
    end
    if (wb_stb_o) begin
      if (slv_c == 0) begin
        slv_bursts++;
        if (slv_bursts == 1) slv_first = cyc_no;
      end
      check("bus_hold", {wb_cyc_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o},
            {1'b1, exp_we, exp_sel, exp_adr, exp_dat});
      term = (slv_b <= RETRY_LIMIT && slv_c == plan_wait[slv_b]) ? plan_kind[slv_b] : 3'b000;
      {wb_rty_i, wb_err_i, wb_ack_i} = term;
      wb_dat_i = slv_rdata;
      slv_c++;
      slv_stb_total++;
      if (term != 3'b000) begin
        slv_b++;
        slv_c = 0;
      end
    end else begin
      slv_c = 0;
      check("cyc_low", {31'd0, wb_cyc_o}, 32'd0);
      {wb_rty_i, wb_err_i, wb_ack_i} = spur_en ? 3'($urandom) : 3'b000;
      wb_dat_i = $urandom;
    end
  end

  task automatic set_plan(input int a, input int w, input logic [2:0] k);
    plan_wait[a] = w;
    plan_kind[a] = k;
  endtask

  // Outcome derived directly from the attempt script.
  task automatic model(input logic we, input logic [31:0] rd, output int st,
                       output logic [31:0] d, output int stb, output int nb);
    st = 3; d = '0; stb = 0; nb = 0;
    for (int a = 0; a <= RETRY_LIMIT; a++) begin
      nb++;
      if (plan_kind[a] == 3'b000 || plan_wait[a] >= TIMEOUT) begin
        stb += TIMEOUT; st = 3; return;
      end
      stb += plan_wait[a] + 1;
      if (plan_kind[a][0]) begin st = 0; d = we ? '0 : rd; return; end
      if (plan_kind[a][1]) begin st = 1; return; end
      if (a == RETRY_LIMIT) begin st = 2; return; end
    end
  endtask

  task automatic issue_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int acc, output bit ok);
    int n;
    exp_we = we; exp_adr = adr; exp_dat = dat; exp_sel = sel;
    cmd_we = we; cmd_addr = adr; cmd_data = dat; cmd_sel = sel; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    ok = cmd_ready;
    acc = cyc_no;
    if (!ok) check("accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr = $urandom; cmd_data = $urandom; cmd_we = 1'($urandom); cmd_sel = 4'($urandom);
  endtask

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] rd, input int hold);
    int acc, n, e_st, e_stb, e_nb;
    logic [31:0] e_d, got_d;
    logic [1:0] got_s;
    bit ok;
    slv_rdata = rd;
    model(we, rd, e_st, e_d, e_stb, e_nb);
    @(negedge clk);
    issue_cmd(we, adr, dat, sel, acc, ok);
    if (!ok) return;
    n = 0;
    while (!rsp_valid && n < 200) begin
      check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin check("rsp_timeout", 0, 1); return; end
    check("latency", cyc_no - acc, e_stb + e_nb);
    check("first_stb", slv_first - acc, 1);
    check("stb_cycles", slv_stb_total, e_stb);
    check("bursts", slv_bursts, e_nb);
    check("status", {30'd0, rsp_status}, e_st);
    check("rdata", rsp_data, e_d);
    got_d = rsp_data;
    got_s = rsp_status;
    repeat (hold) begin
      @(negedge clk);
      check("rsp_hold", {rsp_valid, rsp_status, rsp_data, cmd_ready, wb_cyc_o},
            {1'b1, got_s, got_d, 1'b0, 1'b0});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_released", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  logic [2:0] kinds [8] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b011, 3'b110, 3'b101, 3'b000};

  initial begin
    int acc;
    bit ok;
    for (int a = 0; a <= RETRY_LIMIT; a++) set_plan(a, 0, c_k_ack);

    repeat (3) @(negedge clk);
    check("reset_outputs", {cmd_ready, rsp_valid, rsp_status, rsp_data, wb_adr_o, wb_dat_o,
                            wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o}, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // zero-wait write
    set_plan(0, 0, c_k_ack);
    run_txn(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 32'hCAFE0001, 0);
    // three wait states read, response held off
    set_plan(0, 3, c_k_ack);
    run_txn(1'b0, 32'h200, 32'h0, 4'hF, 32'h12345678, 5);
    // retry twice then ack
    set_plan(0, 0, c_k_rty); set_plan(1, 1, c_k_rty); set_plan(2, 0, c_k_ack);
    run_txn(1'b1, 32'h304, 32'hA5A55A5A, 4'h3, 32'h0, 1);
    // retries exhausted
    for (int a = 0; a <= RETRY_LIMIT; a++) set_plan(a, a, c_k_rty);
    run_txn(1'b0, 32'h408, 32'h0, 4'hC, 32'h11112222, 0);
    // error alone, then ack beating err and rty
    set_plan(0, 2, c_k_err);
    run_txn(1'b0, 32'h50C, 32'h0, 4'hF, 32'h33334444, 0);
    set_plan(0, 1, c_k_ack | c_k_err | c_k_rty);
    run_txn(1'b0, 32'h510, 32'h0, 4'hF, 32'h55556666, 0);
    // timeout with late spurious terminations after release
    spur_en = 1'b1;
    set_plan(0, 0, 3'b000);
    run_txn(1'b1, 32'h614, 32'h77778888, 4'h1, 32'h0, 2);
    // ack on the last cycle before the timeout would fire
    set_plan(0, TIMEOUT - 1, c_k_ack);
    run_txn(1'b0, 32'h618, 32'h0, 4'hF, 32'h9999AAAA, 0);

    // reset while the strobe is up
    set_plan(0, 0, 3'b000);
    @(negedge clk);
    issue_cmd(1'b0, 32'h700, 32'h0, 4'hF, acc, ok);
    repeat (3) @(negedge clk);
    check("stb_before_rst", {31'd0, wb_stb_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_bus", {wb_cyc_o, wb_stb_o, rsp_valid, cmd_ready}, 4'b0000);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_mid_rst", {31'd0, cmd_ready}, 32'd1);
    repeat (20) begin
      @(negedge clk);
      check("no_rsp_after_rst", {31'd0, rsp_valid}, 32'd0);
    end
    set_plan(0, 1, c_k_ack);
    run_txn(1'b0, 32'h704, 32'h0, 4'hF, 32'hBEEF0042, 0);

    // randomised mix
    for (int t = 0; t < 40; t++) begin
      for (int a = 0; a <= RETRY_LIMIT; a++) begin
        set_plan(a, ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                                 : $urandom_range(0, 3),
                 kinds[$urandom_range(0, 7)]);
      end
      run_txn(1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
